// File: rtl/fpu_retire.sv
// FPU result retire stage: 2-entry FIFO with sticky fflags, flag/result legality check and retire counter.
// Optional macro FPU_RETIRE_CANON_NAN_EN canonicalises stored NaN results to 32'h7fc00000.
module fpu_retire #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_o,
   input  logic [4:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_o,
   output logic [4:0]       out_flags,
   output logic [4:0]       fflags,
   input  logic             fflags_clr,
   output logic             viol,
   output logic [CNT_W-1:0] retired
);
   localparam int unsigned DW = 32;
   localparam int unsigned FW = 5;

   logic [1:0]       count_q, count_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [DW-1:0]    out_o_q, out_o_d;
   logic [FW-1:0]    out_flags_q, out_flags_d;
   logic [DW-1:0]    tail_o_q, tail_o_d;
   logic [FW-1:0]    tail_flags_q, tail_flags_d;
   logic [FW-1:0]    fflags_q, fflags_d;
   logic             viol_q, viol_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic          accept;
   logic          pop;
   logic [DW-1:0] store_o;
   logic          bad_combo;
   logic          is_inf, is_qnan, is_sub_or_zero;

   // Legality of flags against the original (uncanonicalised) result
   always_comb begin
      is_inf         = (in_o[30:23] == 8'hff) && (in_o[22:0] == 23'd0);
      is_qnan        = (in_o[30:23] == 8'hff) && in_o[22];
      is_sub_or_zero = (in_o[30:23] == 8'h00);
      bad_combo = (in_flags[2] && !in_flags[0])
                | (in_flags[1] && !in_flags[0])
                | (in_flags[3] && !is_inf)
                | (in_flags[4] && !is_qnan)
                | (in_flags[1] && !is_sub_or_zero);
   end

   always_comb begin
`ifdef FPU_RETIRE_CANON_NAN_EN
      store_o = ((in_o[30:23] == 8'hff) && (in_o[22:0] != 23'd0)) ? 32'h7fc00000 : in_o;
`else
      store_o = in_o;
`endif
   end

   always_comb begin
      count_d      = count_q;
      out_o_d      = out_o_q;
      out_flags_d  = out_flags_q;
      tail_o_d     = tail_o_q;
      tail_flags_d = tail_flags_q;
      accept       = in_valid && in_ready_q;
      pop          = out_valid_q && out_ready;

      // Head lives in the output registers; the tail slot backs it up when full
      case (count_q)
         2'd0: begin
            if (accept) begin
               out_o_d     = store_o;
               out_flags_d = in_flags;
               count_d     = 2'd1;
            end
         end
         2'd1: begin
            if (accept && pop) begin
               out_o_d     = store_o;
               out_flags_d = in_flags;
            end else if (accept) begin
               tail_o_d     = store_o;
               tail_flags_d = in_flags;
               count_d      = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               out_o_d     = tail_o_q;
               out_flags_d = tail_flags_q;
               count_d     = 2'd1;
            end
         end
      endcase

      in_ready_d  = (count_d != 2'd2);
      out_valid_d = (count_d != 2'd0);

      // A set in the same cycle as a clear wins
      fflags_d = (fflags_clr ? FW'(0) : fflags_q) | (accept ? in_flags : FW'(0));
      viol_d   = (fflags_clr ? 1'b0 : viol_q) | (accept && bad_combo);

      retired_d = retired_q;
      if (accept && (retired_q != {CNT_W{1'b1}})) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q      <= 2'd0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_o_q      <= '0;
         out_flags_q  <= '0;
         tail_o_q     <= '0;
         tail_flags_q <= '0;
         fflags_q     <= '0;
         viol_q       <= 1'b0;
         retired_q    <= '0;
      end else begin
         count_q      <= count_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_o_q      <= out_o_d;
         out_flags_q  <= out_flags_d;
         tail_o_q     <= tail_o_d;
         tail_flags_q <= tail_flags_d;
         fflags_q     <= fflags_d;
         viol_q       <= viol_d;
         retired_q    <= retired_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_o     = out_o_q;
   assign out_flags = out_flags_q;
   assign fflags    = fflags_q;
   assign viol      = viol_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_fpu_retire.sv
// Self-checking bench for fpu_retire: directed scenarios plus random traffic against a queue-based model.
module tb_fpu_retire;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [31:0]   in_o;
   logic [4:0]    in_flags;
   logic          out_valid, out_ready;
   logic [31:0]   out_o;
   logic [4:0]    out_flags;
   logic [4:0]    fflags;
   logic          fflags_clr;
   logic          viol;
   logic [CW-1:0] retired;

   int total = 0;
   int bad   = 0;

   logic [36:0] mq[$];
   logic [4:0]  m_fflags;
   logic        m_viol;
   int          m_retired;

   fpu_retire #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_o(in_o), .in_flags(in_flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o), .out_flags(out_flags),
      .fflags(fflags), .fflags_clr(fflags_clr), .viol(viol), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stored(input logic [31:0] o);
`ifdef FPU_RETIRE_CANON_NAN_EN
      if (o[30:23] == 8'hff && o[22:0] != 0) return 32'h7fc00000;
`endif
      return o;
   endfunction

   function automatic logic illegal(input logic [31:0] o, input logic [4:0] f);
      bit nv, dz, of, uf, nx, inf, qnan, sz;
      {nv, dz, of, uf, nx} = f;
      inf  = (o[30:23] == 255) && (o[22:0] == 0);
      qnan = (o[30:23] == 255) && o[22];
      sz   = (o[30:23] == 0);
      return (of && !nx) || (uf && !nx) || (dz && !inf) || (nv && !qnan) || (uf && !sz);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk({tag, ".out_o"}, out_o, mq[0][36:5]);
         chk({tag, ".out_flags"}, 32'(out_flags), 32'(mq[0][4:0]));
      end
      chk({tag, ".fflags"}, 32'(fflags), 32'(m_fflags));
      chk({tag, ".viol"}, 32'(viol), 32'(m_viol));
      chk({tag, ".retired"}, 32'(retired), 32'(m_retired));
   endtask

   // One clock: predict from model state, advance, compare just after the edge
   task automatic cycle(input string tag);
      bit acc, pp;
      acc = in_valid && (mq.size() < 2);
      pp  = out_ready && (mq.size() > 0);
      @(posedge clk);
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back({stored(in_o), in_flags});
      m_fflags = (fflags_clr ? 5'd0 : m_fflags) | (acc ? in_flags : 5'd0);
      m_viol   = (fflags_clr ? 1'b0 : m_viol) | (acc && illegal(in_o, in_flags));
      if (acc && m_retired < (1 << CW) - 1) m_retired++;
      #1;
      check_all(tag);
   endtask

   task automatic drive(input bit v, input logic [31:0] o, input logic [4:0] f, input bit rdy, input bit clr);
      in_valid = v; in_o = o; in_flags = f; out_ready = rdy; fflags_clr = clr;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 32'd0, 5'd0, 0, 0);
      #3;
      mq.delete();
      m_fflags = 0; m_viol = 0; m_retired = 0;
      chk("rst.out_o", out_o, 32'd0);
      chk("rst.out_flags", 32'(out_flags), 32'd0);
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_o();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0: return r;
         1: return {r[31], 8'hff, 23'd0};
         2: return {r[31], 8'hff, 1'b1, r[21:0]};
         3: return {r[31], 8'hff, 1'b0, r[21:1], 1'b1};
         4: return {r[31], 8'h00, r[22:0]};
         default: return {r[31], 31'd0};
      endcase
   endfunction

   initial begin
      rst_n = 1'b1;
      drive(0, 32'd0, 5'd0, 0, 0);
      #1;
      do_reset();

      // Single accept, 1-cycle latency, then drain
      drive(1, 32'h3f800000, 5'b00001, 1, 0);
      cycle("single");
      chk("single.o", out_o, 32'h3f800000);
      chk("single.ret", 32'(retired), 32'd1);
      drive(0, 32'd0, 5'd0, 1, 0);
      cycle("single_drain");
      chk("single.empty", 32'(out_valid), 32'd0);

      // Back-pressure: three back-to-back valids with out_ready low
      drive(1, 32'h40000000, 5'b00001, 0, 0); cycle("bp1");
      drive(1, 32'h40400000, 5'b00001, 0, 0); cycle("bp2");
      chk("bp.full", 32'(in_ready), 32'd0);
      drive(1, 32'h40800000, 5'b00001, 0, 0); cycle("bp3");
      chk("bp.stable", out_o, 32'h40000000);
      drive(0, 32'd0, 5'd0, 1, 0); cycle("bp_pop1");
      chk("bp.second", out_o, 32'h40400000);
      cycle("bp_pop2");

      // OF without NX flags a violation; clear concurrent with NV accept keeps NV
      do_reset();
      drive(1, 32'h7f800000, 5'b00100, 1, 0); cycle("of");
      chk("of.viol", 32'(viol), 32'd1);
      drive(1, 32'h7fc00000, 5'b10000, 1, 1); cycle("clr_set");
      chk("clr_set.fflags", 32'(fflags), 32'h10);
      drive(0, 32'd0, 5'd0, 1, 1); cycle("clr");
      chk("clr.viol", 32'(viol), 32'd0);
      drive(0, 32'd0, 5'd0, 1, 0); cycle("idle");

      // NaN sign/payload handling
      drive(1, 32'hffc12345, 5'b00000, 0, 0); cycle("nan");
`ifdef FPU_RETIRE_CANON_NAN_EN
      chk("nan.o", out_o, 32'h7fc00000);
`else
      chk("nan.o", out_o, 32'hffc12345);
`endif
      drive(0, 32'd0, 5'd0, 1, 0); cycle("nan_drain");

      // Counter saturation, then reset while two entries are held
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 32'h3f800000 + 32'(i), 5'b00001, 1, 0);
         cycle("sat");
      end
      chk("sat.ret", 32'(retired), 32'd3);
      drive(1, 32'h11111111, 5'd0, 0, 0); cycle("hold");
      drive(1, 32'h22222222, 5'd0, 0, 0); cycle("hold");
      @(posedge clk); #1;
      do_reset();
      chk("mid_rst.valid", 32'(out_valid), 32'd0);
      chk("mid_rst.ret", 32'(retired), 32'd0);
      drive(0, 32'd0, 5'd0, 1, 0); cycle("post_rst");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 2) != 0), rand_o(), 5'($urandom),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
